way_select_controller: RTL and testbench

// Sequences the 8-way, 512-bit line Multiplexor of the L2 data array.

---
 rtl/way_select_controller.sv | 131 +++++++++++++
 tb/tb_way_select_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/way_select_controller.sv
// Way select sequencer for the 8-way L2 data array: hit-way encode or tree-PLRU
// victim pick, 8:1 line mux select and per-set replacement state update.
module way_select_controller #(
    parameter int NUM_SETS = 1024,
    parameter int SET_BITS = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SET_BITS-1:0] req_set,
    input  logic [7:0]          req_hit,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [2:0]          resp_way,
    output logic                resp_multi,
    output logic [2:0]          mux_select
);

    typedef enum logic [1:0] {CLEAR, IDLE, LOOKUP, RESP} state_t;

    state_t              state;
    logic [SET_BITS-1:0] clear_idx;
    logic [SET_BITS-1:0] set_q;
    logic [7:0]          hit_q;
    logic [6:0]          plru [NUM_SETS];

    logic [6:0] row;
    logic [6:0] row_next;
    logic [2:0] hit_way;
    logic [2:0] victim;
    logic [2:0] way_sel;
    logic       any_hit;
    logic       multi;

    // Lowest-index hit wins, so scan downward and let the last match stand.
    always_comb begin
        hit_way = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (hit_q[i]) hit_way = 3'(i);
        end
        any_hit = |hit_q;
        multi   = (hit_q & (hit_q - 8'd1)) != 8'd0;
    end

    always_comb begin
        row       = plru[set_q];
        victim[2] = row[0];
        victim[1] = row[0] ? row[2] : row[1];
        case ({row[0], victim[1]})
            2'b00:   victim[0] = row[3];
            2'b01:   victim[0] = row[4];
            2'b10:   victim[0] = row[5];
            default: victim[0] = row[6];
        endcase
        way_sel = any_hit ? hit_way : victim;
    end

    // Every node on the path to the chosen way is flipped to point away from it.
    always_comb begin
        row_next    = row;
        row_next[0] = ~way_sel[2];
        if (way_sel[2]) row_next[2] = ~way_sel[1];
        else            row_next[1] = ~way_sel[1];
        case (way_sel[2:1])
            2'b00:   row_next[3] = ~way_sel[0];
            2'b01:   row_next[4] = ~way_sel[0];
            2'b10:   row_next[5] = ~way_sel[0];
            default: row_next[6] = ~way_sel[0];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CLEAR;
            clear_idx  <= '0;
            set_q      <= '0;
            hit_q      <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= 3'd0;
            resp_multi <= 1'b0;
            mux_select <= 3'd0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_idx <= clear_idx + 1'b1;
                    if (clear_idx == SET_BITS'(NUM_SETS - 1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        set_q     <= req_set;
                        hit_q     <= req_hit;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    resp_hit   <= any_hit;
                    resp_way   <= way_sel;
                    resp_multi <= multi;
                    mux_select <= way_sel;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Kept free of reset so the state table can map onto a RAM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR)       plru[clear_idx] <= 7'd0;
            else if (state == LOOKUP) plru[set_q]     <= row_next;
        end
    end

endmodule

// File: tb/tb_way_select_controller.sv
// Directed bench for way_select_controller with a queue scoreboard and an
// independent heap-indexed tree-PLRU reference.
module tb_way_select_controller;

    localparam int NUM_SETS = 1024;
    localparam int SET_BITS = 10;

    logic                clock;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [SET_BITS-1:0] req_set;
    logic [7:0]          req_hit;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_hit;
    logic [2:0]          resp_way;
    logic                resp_multi;
    logic [2:0]          mux_select;

    typedef struct packed {
        logic       hit;
        logic [2:0] way;
        logic       multi;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] mdl [NUM_SETS];
    int         testCount = 0;
    int         failCount = 0;

    way_select_controller #(.NUM_SETS(NUM_SETS), .SET_BITS(SET_BITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_set    (req_set),
        .req_hit    (req_hit),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way),
        .resp_multi (resp_multi),
        .mux_select (mux_select)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < NUM_SETS; i++) mdl[i] = 7'd0;
    endtask

    task automatic waitReady();
        int n = 0;
        while (req_ready !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        compare("ready_after_clear", {7'd0, req_ready}, 8'd1);
    endtask

    // Reference: node n (1..7) is PLRU bit n-1, children 2n and 2n+1, leaves 8..15.
    task automatic applyStimulus(input logic [SET_BITS-1:0] s, input logic [7:0] h);
        exp_t       e;
        logic [6:0] r;
        int         node;
        r = mdl[s];
        e.hit   = |h;
        e.multi = ($countones(h) > 1);
        e.way   = 3'd0;
        if (e.hit) begin
            for (int i = 7; i >= 0; i--) if (h[i]) e.way = 3'(i);
        end else begin
            node = 1;
            for (int l = 0; l < 3; l++) node = 2 * node + int'(r[node - 1]);
            e.way = 3'(node - 8);
        end
        node = 1;
        for (int l = 2; l >= 0; l--) begin
            r[node - 1] = ~e.way[l];
            node = 2 * node + int'(e.way[l]);
        end
        mdl[s] = r;
        sb.push_back(e);
        req_set   = s;
        req_hit   = h;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        compare("latency_lookup_no_valid", {7'd0, resp_valid}, 8'd0);
        tick();
        compare("latency_resp_valid", {7'd0, resp_valid}, 8'd1);
    endtask

    task automatic checkOutput();
        exp_t e;
        testCount++;
        assert (sb.size() > 0) else begin
            failCount++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare("resp_hit",   {7'd0, resp_hit},   {7'd0, e.hit});
            compare("resp_way",   {5'd0, resp_way},   {5'd0, e.way});
            compare("resp_multi", {7'd0, resp_multi}, {7'd0, e.multi});
            compare("mux_select", {5'd0, mux_select}, {5'd0, e.way});
            compare("req_ready_in_resp", {7'd0, req_ready}, 8'd0);
        end
    endtask

    task automatic transact(input logic [SET_BITS-1:0] s, input logic [7:0] h);
        applyStimulus(s, h);
        checkOutput();
        tick();
        compare("idle_resp_valid", {7'd0, resp_valid}, 8'd0);
        compare("idle_req_ready",  {7'd0, req_ready},  8'd1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_set    = '0;
        req_hit    = 8'd0;
        resp_ready = 1'b1;
        modelClear();
        tick();
        tick();
        compare("rst_resp_valid", {7'd0, resp_valid}, 8'd0);
        compare("rst_req_ready_clearing", {7'd0, req_ready}, 8'd0);
        compare("rst_resp_hit",   {7'd0, resp_hit},   8'd0);
        compare("rst_resp_way",   {5'd0, resp_way},   8'd0);
        compare("rst_resp_multi", {7'd0, resp_multi}, 8'd0);
        compare("rst_mux_select", {5'd0, mux_select}, 8'd0);
        reset = 1'b0;
        waitReady();

        // Repeated misses walk the tree; another set starts fresh.
        transact(10'd5, 8'd0);
        transact(10'd5, 8'd0);
        transact(10'd5, 8'd0);
        transact(10'd5, 8'd0);
        transact(10'd6, 8'd0);

        transact(10'd5, 8'b0010_0000);
        applyStimulus(10'd5, 8'd0);
        testCount++;
        assert (resp_way !== 3'd5) else begin
            failCount++;
            $error("FAIL miss_avoids_way5: observed %0d expected not 5", resp_way);
        end
        checkOutput();
        tick();

        transact(10'd7, 8'b1000_1000);

        // Back-pressure: response held, new requests ignored.
        resp_ready = 1'b0;
        applyStimulus(10'd9, 8'b0000_0100);
        req_set   = 10'd9;
        req_hit   = 8'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            compare("hold_resp_valid", {7'd0, resp_valid}, 8'd1);
            compare("hold_resp_way",   {5'd0, resp_way},   8'd2);
            compare("hold_req_ready",  {7'd0, req_ready},  8'd0);
        end
        req_valid = 1'b0;
        checkOutput();
        resp_ready = 1'b1;
        tick();
        compare("release_resp_valid", {7'd0, resp_valid}, 8'd0);
        compare("release_req_ready",  {7'd0, req_ready},  8'd1);
        tick();
        tick();
        compare("no_extra_resp", {7'd0, resp_valid}, 8'd0);
        transact(10'd9, 8'd0);

        // Reset while in LOOKUP drops the result and restarts the clear.
        req_set   = 10'd5;
        req_hit   = 8'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        compare("rst_lookup_resp_valid", {7'd0, resp_valid}, 8'd0);
        compare("rst_lookup_mux_select", {5'd0, mux_select}, 8'd0);
        compare("rst_lookup_req_ready",  {7'd0, req_ready},  8'd0);
        reset = 1'b0;
        modelClear();
        waitReady();
        transact(10'd5, 8'd0);
        compare("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
